// File: rtl/shiftreg_pkg.sv
// Shared mode encoding for the universal shift register.
package shiftreg_pkg;

   localparam int MODE_W = 3;

   localparam logic [MODE_W-1:0] MODE_HOLD = 3'd0;
   localparam logic [MODE_W-1:0] MODE_SHR  = 3'd1;
   localparam logic [MODE_W-1:0] MODE_SHL  = 3'd2;
   localparam logic [MODE_W-1:0] MODE_ROR  = 3'd3;
   localparam logic [MODE_W-1:0] MODE_ROL  = 3'd4;
   localparam logic [MODE_W-1:0] MODE_LOAD = 3'd5;

endpackage

// File: rtl/shift_frame_counter.sv
// Counts shift/rotate operations and pulses frame_done once every WIDTH of them.
module shift_frame_counter #(
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     shift,
   input  logic                     clear,
   output logic [$clog2(WIDTH)-1:0] shift_cnt,
   output logic                     frame_done
);

   localparam int CW = $clog2(WIDTH);
   // Wrap at WIDTH-1 so non-power-of-two widths still frame correctly.
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shift_cnt  <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (clear) begin
            shift_cnt <= '0;
         end else if (shift) begin
            if (shift_cnt == LAST) begin
               shift_cnt  <= '0;
               frame_done <= 1'b1;
            end else begin
               shift_cnt <= shift_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/universal_shiftreg.sv
// Universal shift register: hold, shift/rotate both ways, parallel load, with frame counter.
module universal_shiftreg
   import shiftreg_pkg::*;
#(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic [MODE_W-1:0]        mode,
   input  logic                     ser_in_r,
   input  logic                     ser_in_l,
   input  logic [WIDTH-1:0]         par_in,
   output logic [WIDTH-1:0]         q,
   output logic                     ser_out_r,
   output logic                     ser_out_l,
   output logic [$clog2(WIDTH)-1:0] shift_cnt,
   output logic                     frame_done
);

   logic [WIDTH-1:0] q_nxt;
   logic             shift;
   logic             clear;

   // Illegal codes fall into default and hold, same as en=0.
   always_comb begin
      q_nxt = q;
      shift = 1'b0;
      clear = 1'b0;
      if (en) begin
         case (mode)
            MODE_SHR: begin
               q_nxt = {ser_in_r, q[WIDTH-1:1]};
               shift = 1'b1;
            end
            MODE_SHL: begin
               q_nxt = {q[WIDTH-2:0], ser_in_l};
               shift = 1'b1;
            end
            MODE_ROR: begin
               q_nxt = {q[0], q[WIDTH-1:1]};
               shift = 1'b1;
            end
            MODE_ROL: begin
               q_nxt = {q[WIDTH-2:0], q[WIDTH-1]};
               shift = 1'b1;
            end
            MODE_LOAD: begin
               q_nxt = par_in;
               clear = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) q <= RESET_VAL;
      else      q <= q_nxt;
   end

   assign ser_out_r = q[0];
   assign ser_out_l = q[WIDTH-1];

   shift_frame_counter #(.WIDTH(WIDTH)) u_frame_cnt (
      .clk        (clk),
      .rst        (rst),
      .shift      (shift),
      .clear      (clear),
      .shift_cnt  (shift_cnt),
      .frame_done (frame_done)
   );

endmodule
